// File: rtl/relu_pool_framer.sv
// rtl/relu_pool_framer.sv - per-lane ReLU and max-pool window framing with a fixed 2-cycle latency
// Optional macro RELU_CLAMP_EN: positive lanes saturate at CLAMP_MAX (ReLU-N).
module relu_pool_framer #(
  parameter int FEATURE_WIDTH         = 8,
  parameter int NO_FEATURE_PLANES_PAR = 3,
  parameter int NO_FEATURE_PLANES_SER = 3,
  parameter int POOL_SIZE             = 4,
  parameter int CLAMP_MAX             = 2**(FEATURE_WIDTH-1)-1,
  parameter int STREAM_WIDTH          = FEATURE_WIDTH*NO_FEATURE_PLANES_PAR
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STREAM_WIDTH-1:0] conv_stream,
  input  logic                    conv_valid,
  input  logic                    conv_sof,
  output logic [STREAM_WIDTH-1:0] feature_stream,
  output logic                    feature_valid,
  output logic                    feature_first,
  output logic                    feature_last,
  output logic                    frame_error
);

  localparam int SER_W  = (NO_FEATURE_PLANES_SER > 1) ? $clog2(NO_FEATURE_PLANES_SER) : 1;
  localparam int POOL_W = (POOL_SIZE > 1) ? $clog2(POOL_SIZE) : 1;
  localparam logic [SER_W-1:0]  SER_LAST  = SER_W'(NO_FEATURE_PLANES_SER-1);
  localparam logic [POOL_W-1:0] POOL_LAST = POOL_W'(POOL_SIZE-1);

`ifdef RELU_CLAMP_EN
  localparam logic [FEATURE_WIDTH-1:0] CLAMP_VAL = FEATURE_WIDTH'(CLAMP_MAX);
`else
  logic unused_clamp;
  assign unused_clamp = (CLAMP_MAX != 0);
`endif

  logic [SER_W-1:0]        ser_count, ser_next;
  logic [POOL_W-1:0]       pool_count, pool_next;
  logic                    at_origin;
  logic                    beat_first, beat_last, beat_error;

  logic [STREAM_WIDTH-1:0] s1_data;
  logic                    s1_valid, s1_first, s1_last, s1_error;
  logic [STREAM_WIDTH-1:0] relu_data;

  function automatic logic [FEATURE_WIDTH-1:0] relu_lane(input logic [FEATURE_WIDTH-1:0] v);
    logic [FEATURE_WIDTH-1:0] r;
    r = v[FEATURE_WIDTH-1] ? '0 : v;
`ifdef RELU_CLAMP_EN
    if (r > CLAMP_VAL) r = CLAMP_VAL;
`endif
    return r;
  endfunction

  // Flags are judged against the counters as this beat sees them; sof overrides to origin.
  always_comb begin
    at_origin  = (ser_count == '0) && (pool_count == '0);
    ser_next   = ser_count;
    pool_next  = pool_count;
    beat_first = 1'b0;
    beat_last  = 1'b0;
    beat_error = 1'b0;
    if (conv_valid) begin
      if (conv_sof) begin
        beat_first = 1'b1;
        beat_error = !at_origin;
        ser_next   = SER_W'(1);
        pool_next  = '0;
      end else begin
        beat_first = at_origin;
        beat_last  = (ser_count == SER_LAST) && (pool_count == POOL_LAST);
        if (ser_count == SER_LAST) begin
          ser_next  = '0;
          pool_next = (pool_count == POOL_LAST) ? '0 : pool_count + POOL_W'(1);
        end else begin
          ser_next  = ser_count + SER_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ser_count  <= '0;
      pool_count <= '0;
    end else begin
      ser_count  <= ser_next;
      pool_count <= pool_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_data  <= '0;
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_error <= 1'b0;
    end else begin
      if (conv_valid) s1_data <= conv_stream;
      s1_valid <= conv_valid;
      s1_first <= beat_first;
      s1_last  <= beat_last;
      s1_error <= beat_error;
    end
  end

  always_comb begin
    relu_data = '0;
    for (int i = 0; i < NO_FEATURE_PLANES_PAR; i++) begin
      relu_data[FEATURE_WIDTH*i +: FEATURE_WIDTH] = relu_lane(s1_data[FEATURE_WIDTH*i +: FEATURE_WIDTH]);
    end
  end

  // Output data only moves on valid beats so it holds through gaps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      feature_stream <= '0;
      feature_valid  <= 1'b0;
      feature_first  <= 1'b0;
      feature_last   <= 1'b0;
      frame_error    <= 1'b0;
    end else begin
      if (s1_valid) feature_stream <= relu_data;
      feature_valid <= s1_valid;
      feature_first <= s1_first;
      feature_last  <= s1_last;
      frame_error   <= s1_error;
    end
  end

endmodule

// File: tb/tb_relu_pool_framer.sv
// tb/tb_relu_pool_framer.sv - scoreboard bench for relu_pool_framer
`timescale 1ns/1ps
module tb_relu_pool_framer;
  localparam int FW    = 8;
  localparam int PAR   = 3;
  localparam int SER   = 3;
  localparam int POOL  = 4;
  localparam int SW    = FW*PAR;
  localparam int WIN   = SER*POOL;
  localparam int CLAMP = 6;

  typedef struct packed {
    logic [SW-1:0] data;
    logic          first;
    logic          last;
    logic          err;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [SW-1:0] conv_stream = '0;
  logic          conv_valid = 1'b0;
  logic          conv_sof = 1'b0;
  logic [SW-1:0] feature_stream;
  logic          feature_valid, feature_first, feature_last, frame_error;

  exp_t          q[$];
  int            win_idx = 0;
  int            tests = 0;
  int            fails = 0;
  logic [SW-1:0] last_data = '0;
  logic          vd1, vd2;

  relu_pool_framer #(
    .FEATURE_WIDTH(FW), .NO_FEATURE_PLANES_PAR(PAR), .NO_FEATURE_PLANES_SER(SER),
    .POOL_SIZE(POOL), .CLAMP_MAX(CLAMP)
  ) dut (
    .clk(clk), .rst(rst), .conv_stream(conv_stream), .conv_valid(conv_valid),
    .conv_sof(conv_sof), .feature_stream(feature_stream), .feature_valid(feature_valid),
    .feature_first(feature_first), .feature_last(feature_last), .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  // Expected feature_valid is the input valid two clocks later; reset empties it.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      vd1 <= 1'b0;
      vd2 <= 1'b0;
    end else begin
      vd1 <= conv_valid;
      vd2 <= vd1;
    end
  end

  function automatic logic [FW-1:0] ref_lane(input logic [FW-1:0] raw);
    int v;
    v = int'($signed(raw));
    if (v < 0) v = 0;
`ifdef RELU_CLAMP_EN
    if (v > CLAMP) v = CLAMP;
`endif
    return FW'(v);
  endfunction

  task automatic beat(input logic v, input logic s, input logic [SW-1:0] d);
    exp_t e;
    @(posedge clk);
    #1;
    conv_valid  = v;
    conv_sof    = s;
    conv_stream = d;
    if (v) begin
      e.err = 1'b0;
      if (s) begin
        e.err   = (win_idx != 0);
        win_idx = 0;
      end
      e.first = (win_idx == 0);
      e.last  = (win_idx == WIN-1);
      for (int i = 0; i < PAR; i++) e.data[FW*i +: FW] = ref_lane(d[FW*i +: FW]);
      q.push_back(e);
      win_idx = (win_idx + 1) % WIN;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst        = 1'b1;
    conv_valid = 1'b0;
    conv_sof   = 1'b0;
    q.delete();
    win_idx = 0;
    #1;
    tests++;
    if ({feature_stream, feature_valid, feature_first, feature_last, frame_error} !== {{SW{1'b0}}, 4'b0}) begin
      fails++;
      $display("FAIL async_reset: got data=%h v=%b f=%b l=%b e=%b, need all zero",
               feature_stream, feature_valid, feature_first, feature_last, frame_error);
    end
    @(posedge clk);
    #3;
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      last_data = '0;
    end else begin
      tests++;
      if (feature_valid !== vd2) begin
        fails++;
        $display("FAIL valid_timing at %0t: got %b, need %b", $time, feature_valid, vd2);
      end
      if (feature_valid) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_beat at %0t: got data=%h with nothing expected", $time, feature_stream);
        end else begin
          e = q.pop_front();
          if ({feature_stream, feature_first, feature_last, frame_error} !== e) begin
            fails++;
            $display("FAIL beat at %0t: got data=%h f=%b l=%b e=%b, need data=%h f=%b l=%b e=%b",
                     $time, feature_stream, feature_first, feature_last, frame_error,
                     e.data, e.first, e.last, e.err);
          end
          last_data = e.data;
        end
      end else begin
        tests++;
        if ({feature_stream, feature_first, feature_last, frame_error} !== {last_data, 3'b000}) begin
          fails++;
          $display("FAIL idle_hold at %0t: got data=%h f=%b l=%b e=%b, need data=%h and flags 0",
                   $time, feature_stream, feature_first, feature_last, frame_error, last_data);
        end
      end
    end
  end

  initial begin
    int waited;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;

    for (int i = 0; i < 5; i++) beat(1'b1, i == 0, SW'($urandom));
    do_reset();

    for (int i = 0; i < 24; i++) beat(1'b1, i == 0, SW'($urandom));

    beat(1'b1, 1'b1, {8'h00, 8'h7F, 8'h80});
    beat(1'b1, 1'b0, {8'h40, 8'h01, 8'hFF});
    beat(1'b1, 1'b0, {8'h07, 8'h06, 8'h05});
    beat(1'b1, 1'b0, {8'h90, 8'h90, 8'h90});
    beat(1'b1, 1'b0, {8'h7F, 8'h80, 8'h07});

    for (int i = 0; i < 2*WIN; i++) beat(i % 2 == 0, i == 0, SW'($urandom));

    for (int i = 0; i < 5; i++) beat(1'b1, i == 0, SW'($urandom));
    for (int i = 0; i < 20; i++) beat(1'b1, i == 0, SW'($urandom));

    for (int i = 0; i < 8; i++) beat(1'b1, i == 0, SW'($urandom));
    do_reset();
    for (int i = 0; i < 24; i++) beat(1'b1, 1'b0, SW'($urandom));

    for (int i = 0; i < 400; i++)
      beat($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, SW'($urandom));

    beat(1'b0, 1'b0, '0);
    waited = 0;
    while (q.size() != 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d beats still pending, need 0", q.size());
    end
    @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
